// File: rtl/serial_word_assembler.sv
// serial_word_assembler: collects a serial bit stream into N-bit words, strobing load_out per word and clear_out on flush
//   clk        system clock
//   clear      synchronous active-high reset
//   bit_in     serial data, qualified by bit_valid
//   flush      aborts the partial word and pulses clear_out next cycle
//   data_out   last completed word (registered)
//   load_out   one-cycle strobe marking a new data_out
//   clear_out  one-cycle strobe to clear the downstream register
//   busy       a partial word is held
//   bit_count  bits accumulated in the current partial word
module serial_word_assembler #(
  parameter int N = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  input  logic                 flush,
  output logic [N-1:0]         data_out,
  output logic                 load_out,
  output logic                 clear_out,
  output logic                 busy,
  output logic [$clog2(N)-1:0] bit_count
);
  localparam int CW = $clog2(N);
  logic [N-1:0] sr, sr_next;
  logic [CW-1:0] cnt;
  logic last;
  assign sr_next = MSB_FIRST ? {sr[N-2:0], bit_in} : {bit_in, sr[N-1:1]};
  assign last = cnt == CW'(N - 1);
  assign busy = cnt != '0;
  assign bit_count = cnt;
  always_ff @(posedge clk) begin
    if (clear) begin
      sr <= '0;
      cnt <= '0;
      data_out <= '0;
      load_out <= 1'b0;
      clear_out <= 1'b0;
    end else begin
      load_out <= 1'b0;
      clear_out <= 1'b0;
      if (flush) begin
        sr <= '0;
        cnt <= '0;
        data_out <= '0;
        clear_out <= 1'b1;
      end else if (bit_valid) begin
        if (last) begin
          data_out <= sr_next;
          load_out <= 1'b1;
          sr <= '0;
          cnt <= '0;
        end else begin
          sr <= sr_next;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/serial_word_assembler.md
Name: serial_word_assembler

Overview:
Upstream feeder for the team's load/clear register. It collects a serial bit stream into an N-bit word. When the word is complete it presents the word on data_out with a one-cycle load_out strobe, which wires to the register's in/load. A flush input aborts a partial word and emits a one-cycle clear_out, which wires to the register's clear.

Parameters:
N, 8, word width in bits; must be >= 2.
MSB_FIRST, 1, 1 = first received bit lands in data_out[N-1]; 0 = first received bit lands in data_out[0].

Ports:
clk  input  1  system clock; all state changes on posedge.
clear  input  1  reset; synchronous, active-high.
bit_in  input  1  serial data bit; sampled only when bit_valid=1.
bit_valid  input  1  qualifies bit_in for the current cycle.
flush  input  1  abort the partial word and pulse clear_out.
data_out  output  N  last completed word (registered); feeds the downstream register's in.
load_out  output  1  one-cycle strobe; data_out holds a new word this cycle.
clear_out  output  1  one-cycle strobe to clear the downstream register.
busy  output  1  1 while a partial word (1..N-1 bits) is held.
bit_count  output  $clog2(N)  number of bits accumulated in the current partial word.

Behaviour:
- Internal state: shift register sr[N-1:0] and counter cnt (0..N-1). busy = (cnt != 0). bit_count = cnt.
- Reset: while clear=1 at posedge, set sr=0, cnt=0, data_out=0, load_out=0, clear_out=0. Reset overrides flush and bit_valid. Reset does not generate a clear_out pulse. A partial word in progress at reset is discarded.
- Priority per cycle (clear=0): flush > bit_valid > idle.
- Flush: set sr=0, cnt=0, data_out=0. clear_out=1 in the next cycle only. load_out=0 that cycle. bit_in is ignored that cycle, even if bit_valid=1.
- Flush with cnt=0 (idle) still pulses clear_out.
- Held flush (flush=1 for k cycles) produces k consecutive clear_out cycles.
- bit_valid=1, cnt<N-1:
  - MSB_FIRST=1: sr <= {sr[N-2:0], bit_in}.
  - MSB_FIRST=0: sr <= {bit_in, sr[N-1:1]}.
  - cnt <= cnt+1.
- bit_valid=1, cnt==N-1 (final bit):
  - data_out <= sr combined with bit_in, using the same shift rule.
  - load_out=1 in the next cycle.
  - cnt <= 0; sr <= 0.
- Latency: load_out and the new data_out both appear in the cycle after the Nth valid bit is sampled, i.e. at the posedge following that bit.
- load_out is high exactly one cycle per completed word.
- data_out holds its value until the next completion, flush, or reset.
- bit_valid=0: sr and cnt hold. Gaps of any length between valid bits are allowed.
- Back-to-back words: a valid bit in the same cycle load_out is high is bit 1 of the next word. Continuous streaming therefore yields one load_out every N cycles.
- Flush in the same cycle as the final bit: flush wins. No load_out is generated, data_out=0, and clear_out pulses.
- load_out and clear_out are never high in the same cycle.
- All outputs are registered; no combinational path from inputs to outputs except busy/bit_count, which decode registered cnt.

Test Plan:
- Reset, then N=8, MSB_FIRST=1, bit_valid=1 for 8 consecutive cycles with bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5 and load_out=1 for exactly one cycle, the cycle after the 8th bit. busy=0 in that cycle.
- Same bits with bit_valid deasserted for 3 cycles after bit 4 -> bit_count holds at 4 during the gap. Completion is 3 cycles later than in the first test, with data_out=8'hA5.
- MSB_FIRST=0, bits 1,0,1,0,0,1,0,1 -> data_out=8'hA5 reversed = 8'hA5. Then bits 1,1,0,0,0,0,0,0 -> data_out=8'h03.
- 5 bits accepted, then flush=1 for one cycle -> clear_out=1 for one cycle, data_out=0, bit_count=0, busy=0. The next 8 bits assemble a correct fresh word.
- 7 bits accepted, then bit_valid=1 and flush=1 together -> no load_out, clear_out=1, data_out=0. Streaming 16 bits continuously afterwards gives load_out exactly 8 cycles apart.
- clear=1 asserted mid-word (cnt=6) -> all outputs 0 next cycle, clear_out stays 0. The subsequent 8 bits give a correct word, confirming no leftover partial bits.
